// File: rtl/div10x5u_seq.sv
// Sequential unsigned divider: 10-bit dividend / 5-bit divisor, one restoring
// step per clock, with a valid/ready handshake on both sides.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   dividend/divisor pair offered
//   in_ready   block can accept a pair (IDLE only)
//   A, B       dividend (10 bits), divisor (5 bits)
//   out_valid  result held on Q/R/dbz
//   out_ready  consumer takes the result (honoured in DONE only)
//   Q, R       quotient (10 bits), remainder (5 bits)
//   dbz        divide-by-zero flag for the current result
module div10x5u_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [9:0]  A,
    input  logic [4:0]  B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [9:0]  Q,
    output logic [4:0]  R,
    output logic        dbz
);

    localparam int unsigned A_W = 10;
    localparam int unsigned B_W = 5;
    localparam int unsigned P_W = B_W + 1;   // partial remainder width
    localparam int unsigned S_W = P_W + 1;   // shifted partial remainder width
    localparam int unsigned C_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [A_W-1:0] work;   // dividend shifts out of the top, quotient bits shift in at the bottom
    logic [B_W-1:0] div;
    logic [P_W-1:0] part;
    logic [C_W-1:0] cnt;

    logic [S_W-1:0] shifted_c;
    logic           take_c;
    logic [S_W-1:0] rem_c;

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
    always_comb begin
        shifted_c = {part, work[A_W-1]};
        take_c    = (shifted_c >= S_W'(div));
        rem_c     = shifted_c;
        if (take_c) begin
            rem_c = shifted_c - S_W'(div);
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Q         <= '0;
            R         <= '0;
            dbz       <= 1'b0;
            work      <= '0;
            div       <= '0;
            part      <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (B == '0) begin
                            // Divide by zero resolves immediately with a saturated quotient.
                            Q         <= '1;
                            R         <= '0;
                            dbz       <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            work  <= A;
                            div   <= B;
                            part  <= '0;
                            cnt   <= '0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    work <= {work[A_W-2:0], take_c};
                    part <= P_W'(rem_c);
                    cnt  <= cnt + C_W'(1);
                    if (cnt == C_W'(A_W - 1)) begin
                        // Results become visible only on the final step.
                        Q         <= {work[A_W-2:0], take_c};
                        R         <= B_W'(rem_c);
                        dbz       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div10x5u_seq.sv
// Self-checking bench for div10x5u_seq: directed corner cases followed by a
// randomized sweep, compared against plain integer division.
module tb_div10x5u_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] A;
    logic [4:0] B;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] Q;
    logic [4:0] R;
    logic       dbz;

    int tests = 0;
    int fails = 0;

    logic [9:0] prev_q = '0;
    logic [4:0] prev_r = '0;

    always #5 clk = ~clk;

    div10x5u_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .R         (R),
        .dbz       (dbz)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full transaction: offer, wait for result with exact latency,
    // hold under backpressure for 'hold' cycles, then consume.
    task automatic run_txn(input logic [9:0] a, input logic [4:0] b,
                           input int hold, input bit chaos);
        logic [9:0] eq;
        logic [4:0] er;
        logic       ed;
        int         exp_lat;
        int         lat;
        if (b == 5'd0) begin
            eq = 10'h3FF; er = 5'd0; ed = 1'b1; exp_lat = 1;
        end else begin
            eq = 10'(int'(a) / int'(b));
            er = 5'(int'(a) % int'(b));
            ed = 1'b0; exp_lat = 11;
        end

        check("in_ready_idle", in_ready, 1);
        A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
        step();
        lat = 1;
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            check("in_ready_busy", in_ready, 0);
            check("q_hidden", Q, prev_q);
            check("r_hidden", R, prev_r);
            if (chaos) begin
                A = 10'($urandom); B = 5'($urandom);
                in_valid = 1'($urandom); out_ready = 1'($urandom);
            end
            step();
            lat++;
        end
        out_ready = 1'b0;
        check("latency", lat, exp_lat);
        check("out_valid", out_valid, 1);
        check("q", Q, eq);
        check("r", R, er);
        check("dbz", dbz, ed);

        for (int i = 0; i < hold; i++) begin
            if (chaos) begin
                A = 10'($urandom); B = 5'($urandom); in_valid = 1'($urandom);
            end
            step();
            check("hold_valid", out_valid, 1);
            check("hold_q", Q, eq);
            check("hold_r", R, er);
            check("hold_dbz", dbz, ed);
            check("hold_in_ready", in_ready, 0);
        end

        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("consumed_valid", out_valid, 0);
        check("consumed_in_ready", in_ready, 1);
        prev_q = eq;
        prev_r = er;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
        step();
        step();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_q", Q, 0);
        check("rst_r", R, 0);
        check("rst_dbz", dbz, 0);
        rst_n = 1'b1;

        // Directed corner cases
        run_txn(10'd1000, 5'd31, 0, 1'b0);
        run_txn(10'd1023, 5'd1,  0, 1'b0);
        run_txn(10'd1023, 5'd31, 0, 1'b0);
        run_txn(10'd5,    5'd0,  0, 1'b0);
        run_txn(10'd0,    5'd7,  0, 1'b0);
        run_txn(10'd100,  5'd9,  5, 1'b1);

        // Reset on the 5th CALC edge discards the operation
        A = 10'd500; B = 5'd7; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        step();
        rst_n = 1'b1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_q", Q, 0);
        check("midrst_r", R, 0);
        check("midrst_dbz", dbz, 0);
        prev_q = '0;
        prev_r = '0;
        run_txn(10'd77, 5'd5, 0, 1'b0);

        // Every divisor against extreme dividends
        for (int b = 0; b < 32; b++) begin
            run_txn(10'd0,    5'(b), 0, 1'b0);
            run_txn(10'd1023, 5'(b), 0, 1'b1);
        end

        // Randomized sweep with random backpressure and input noise
        for (int n = 0; n < 500; n++) begin
            run_txn(10'($urandom), 5'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
